// File: rtl/match_window_counter.sv
// Counts single-cycle match pulses over a fixed window of WINDOW clock cycles
// and holds the result until the consumer completes a valid/ready handshake.
module match_window_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             start,
  input  logic             out_ready,
  output logic             busy,
  output logic             count_valid,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [15:0]      TIMER_LOAD = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r;
  logic [15:0]      timer_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] count_out_r;
  logic             overflow_r;
  logic             count_valid_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             ovf_next_s;

  // Next counter value for a sampled edge: saturate at CNT_MAX and flag overflow
  always_comb begin
    cnt_next_s = cnt_r;
    ovf_next_s = overflow_r;
    if (pulse_in) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = cnt_r;
        ovf_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
        ovf_next_s = overflow_r;
      end
    end else begin
      cnt_next_s = cnt_r;
      ovf_next_s = overflow_r;
    end
  end

  // Window FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      timer_r       <= 16'd0;
      cnt_r         <= '0;
      count_out_r   <= '0;
      overflow_r    <= 1'b0;
      count_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            timer_r    <= TIMER_LOAD;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= COUNT;
          end else begin
            state_r <= IDLE;
          end
        end
        COUNT: begin
          cnt_r      <= cnt_next_s;
          overflow_r <= ovf_next_s;
          timer_r    <= timer_r - 16'd1;
          // Timer at zero marks the last sampled edge; that edge's pulse is included
          if (timer_r == 16'd0) begin
            timer_r       <= 16'd0;
            count_out_r   <= cnt_next_s;
            count_valid_r <= 1'b1;
            state_r       <= REPORT;
          end else begin
            state_r <= COUNT;
          end
        end
        REPORT: begin
          if (count_valid_r && out_ready) begin
            count_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r <= REPORT;
          end
        end
        default: begin
          state_r       <= IDLE;
          count_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign count_valid = count_valid_r;
  assign count_out   = count_out_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench: three instances (default, CNT_W=3, WINDOW=1) checked
// against a window-sum model with saturation computed from the pulses driven.
module tb_match_window_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] pulse_v;
  logic [2:0] rdy_v;
  wire  [2:0] busy_v;
  wire  [2:0] cv_v;
  wire  [2:0] ovf_v;
  wire  [4:0] co0;
  wire  [2:0] co1;
  wire  [4:0] co2;

  int tests_run = 0;
  int fails     = 0;
  int win[3]    = '{16, 16, 1};
  int maxv[3]   = '{31, 7, 31};

  always #5 clk = ~clk;

  match_window_counter #(.WINDOW(16), .CNT_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_v[0]), .start(start_v[0]),
    .out_ready(rdy_v[0]), .busy(busy_v[0]), .count_valid(cv_v[0]),
    .count_out(co0), .overflow(ovf_v[0]));

  match_window_counter #(.WINDOW(16), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_v[1]), .start(start_v[1]),
    .out_ready(rdy_v[1]), .busy(busy_v[1]), .count_valid(cv_v[1]),
    .count_out(co1), .overflow(ovf_v[1]));

  match_window_counter #(.WINDOW(1), .CNT_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_v[2]), .start(start_v[2]),
    .out_ready(rdy_v[2]), .busy(busy_v[2]), .count_valid(cv_v[2]),
    .count_out(co2), .overflow(ovf_v[2]));

  function automatic logic [4:0] co_of(input int s);
    case (s)
      0:       return co0;
      1:       return {2'b00, co1};
      default: return co2;
    endcase
  endfunction

  // {busy, count_valid, overflow, count_out}
  function automatic logic [7:0] obs(input int s);
    return {busy_v[s], cv_v[s], ovf_v[s], co_of(s)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0; start_v = 3'b000; pulse_v = 3'b000; rdy_v = 3'b000;
    #1;
    for (int s = 0; s < 3; s++) begin
      got = obs(s);
      tests_run++;
      if (got !== 8'h00) begin
        fails++;
        $display("FAIL reset_state inst%0d got=%h exp=00", s, got);
      end
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  // mode 0: random pulses, 1: pulses on every edge, 2: pulses on edges 1, 5 and 16
  task automatic run_window(input int s, input int mode, input int hold);
    int n = win[s];
    int sum = 0;
    int expc;
    logic expo;
    logic p;
    logic [7:0] got;
    logic [7:0] exp;
    start_v[s] = 1'b1;
    step();
    start_v[s] = 1'b0;
    tests_run++;
    if (busy_v[s] !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start inst%0d got=%b exp=1", s, busy_v[s]);
    end
    for (int i = 1; i <= n; i++) begin
      case (mode)
        0:       p = 1'($urandom % 2);
        1:       p = 1'b1;
        default: p = (i == 1 || i == 5 || i == 16);
      endcase
      pulse_v[s] = p;
      sum += int'(p);
      start_v[s] = 1'($urandom % 2);
      rdy_v[s]   = 1'($urandom % 2);
      step();
      if (i < n) begin
        tests_run++;
        if ({busy_v[s], cv_v[s]} !== 2'b10) begin
          fails++;
          $display("FAIL counting inst%0d edge%0d got=%b exp=10", s, i, {busy_v[s], cv_v[s]});
        end
      end
    end
    expc = (sum > maxv[s]) ? maxv[s] : sum;
    expo = (sum > maxv[s]);
    exp  = {1'b1, 1'b1, expo, 5'(expc)};
    got  = obs(s);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL result inst%0d mode%0d got=%h exp=%h", s, mode, got, exp);
    end
    for (int h = 0; h < hold; h++) begin
      rdy_v[s]   = 1'b0;
      start_v[s] = 1'($urandom % 2);
      pulse_v[s] = 1'($urandom % 2);
      step();
      got = obs(s);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL report_hold inst%0d cyc%0d got=%h exp=%h", s, h, got, exp);
      end
    end
    rdy_v[s]   = 1'b1;
    start_v[s] = 1'($urandom % 2);
    pulse_v[s] = 1'($urandom % 2);
    step();
    exp = {1'b0, 1'b0, expo, 5'(expc)};
    got = obs(s);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL handshake inst%0d got=%h exp=%h", s, got, exp);
    end
    rdy_v[s] = 1'b0; start_v[s] = 1'b0; pulse_v[s] = 1'($urandom % 2);
    step();
    got = obs(s);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL idle_hold inst%0d got=%h exp=%h", s, got, exp);
    end
    pulse_v[s] = 1'b0;
  endtask

  task automatic test_basic();
    run_window(0, 2, 0);
    run_window(0, 0, 3);
    run_window(0, 0, 0);
  endtask

  task automatic test_saturation();
    run_window(1, 1, 1);
    run_window(1, 0, 2);
  endtask

  task automatic test_pending_hold();
    run_window(0, 0, 10);
  endtask

  task automatic test_window_one();
    run_window(2, 1, 0);
    run_window(2, 0, 2);
  endtask

  task automatic test_back_to_back();
    int sum;
    logic p;
    logic [7:0] got;
    logic [7:0] exp;
    start_v[0] = 1'b1; rdy_v[0] = 1'b1;
    step();
    for (int w = 0; w < 4; w++) begin
      sum = 0;
      for (int i = 1; i <= 16; i++) begin
        p = 1'($urandom % 2);
        pulse_v[0] = p;
        sum += int'(p);
        step();
      end
      exp = {1'b1, 1'b1, 1'b0, 5'(sum)};
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_result win%0d got=%h exp=%h", w, got, exp);
      end
      pulse_v[0] = 1'($urandom % 2);
      step();
      exp = {1'b0, 1'b0, 1'b0, 5'(sum)};
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_handshake win%0d got=%h exp=%h", w, got, exp);
      end
      if (w == 3) start_v[0] = 1'b0;
      pulse_v[0] = 1'($urandom % 2);
      step();
      exp = {(w != 3), 1'b0, 1'b0, 5'(sum)};
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_restart win%0d got=%h exp=%h", w, got, exp);
      end
    end
    rdy_v[0] = 1'b0; pulse_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    logic [7:0] got;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      pulse_v[0] = 1'($urandom % 2);
      step();
    end
    pulse_v[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    got = obs(0);
    tests_run++;
    if (got !== 8'h00) begin
      fails++;
      $display("FAIL async_reset got=%h exp=00", got);
    end
    step();
    rst_n = 1'b1;
    pulse_v[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse_v[0] = 1'($urandom % 2);
      step();
      tests_run++;
      if ({busy_v[0], cv_v[0]} !== 2'b00) begin
        fails++;
        $display("FAIL no_result_after_reset cyc%0d got=%b exp=00", i, {busy_v[0], cv_v[0]});
      end
    end
    pulse_v[0] = 1'b0;
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run_window(0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_pending_hold();
    test_window_one();
    test_back_to_back();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

Interface
- REQ-001: The block SHALL have parameter WINDOW, default 16: length of the counting window in clock cycles. Legal range is 1..65535.
- REQ-002: The block SHALL have parameter CNT_W, default 5: width of the event counter in bits.
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005: The block SHALL have port pulse_in, input, 1 bit: single-cycle match pulse from the upstream x1/x2 match detector. Each high cycle is one event.
- REQ-006: The block SHALL have port start, input, 1 bit: request to open a counting window.
- REQ-007: The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
- REQ-008: The block SHALL have port busy, output, 1 bit: high in COUNT and REPORT.
- REQ-009: The block SHALL have port count_valid, output, 1 bit: a result is held on count_out.
- REQ-010: The block SHALL have port count_out, output, CNT_W bits: number of events in the last window.
- REQ-011: The block SHALL have port overflow, output, 1 bit: the counter saturated during the reported window.

Function
- REQ-012: The FSM SHALL have exactly three states: IDLE, COUNT and REPORT. All outputs SHALL be registered.
- REQ-013: In IDLE, start=1 on a rising edge SHALL load the window timer with WINDOW-1, clear the counter and overflow, and go to COUNT. start=0 SHALL keep the FSM in IDLE.
- REQ-014: In COUNT, pulse_in SHALL be sampled on exactly WINDOW consecutive rising edges, starting at the edge after start is accepted.
- REQ-015: On each sampled edge with pulse_in=1, the counter SHALL increment by 1.
- REQ-016: When the counter already equals 2^CNT_W-1 and pulse_in=1, it SHALL hold that value and set overflow. Overflow SHALL stay set until the next window starts.
- REQ-017: The timer SHALL decrement on each COUNT edge. On the edge where the timer is 0 (the last sampled edge), the FSM SHALL go to REPORT.
- REQ-018: On that same last edge, count_out SHALL load the final count, including any pulse on that edge, and count_valid SHALL go to 1.
- REQ-019: In REPORT, count_out, overflow and count_valid SHALL hold stable until count_valid&&out_ready on a rising edge.
- REQ-020: On the count_valid&&out_ready edge, count_valid SHALL go to 0 and the FSM SHALL go to IDLE. count_out and overflow SHALL keep their last values.
- REQ-021: start SHALL be ignored in COUNT and in REPORT, including on the handshake edge. A new window SHALL need start in IDLE, at the earliest one cycle after the handshake.
- REQ-022: pulse_in SHALL be ignored in IDLE and REPORT.
- REQ-023: out_ready SHALL be ignored unless count_valid=1. out_ready may be held high permanently; REPORT then lasts exactly one cycle.
- REQ-024: With WINDOW=1, the window SHALL be the single edge after start; count_valid rises on that edge.
- REQ-025: Latency from the start edge to count_valid=1 SHALL be WINDOW cycles.
- REQ-026: busy SHALL be 1 from the start edge through the handshake edge, and 0 otherwise.

Reset
- REQ-027: rst_n=0 SHALL immediately (asynchronously) force IDLE, counter=0, timer=0, count_out=0, count_valid=0, overflow=0 and busy=0.
- REQ-028: Reset asserted mid-COUNT or mid-REPORT SHALL discard the partial or pending result; no count_valid follows the release.
- REQ-029: After rst_n rises, the first rising edge SHALL be able to accept start.

Verification
- REQ-030: Defaults; start pulse; pulse_in high on window edges 1, 5, 16 -> count_valid rises 16 cycles after start, count_out=3, overflow=0.
- REQ-031: CNT_W=3, WINDOW=16; pulse_in held high for the whole window -> count_out=7, overflow=1.
- REQ-032: Result pending with out_ready=0 for 10 cycles while start and pulse_in toggle -> outputs stable, busy=1. Then out_ready=1 -> count_valid=0 next edge, FSM in IDLE.
- REQ-033: out_ready tied high; start asserted every cycle -> windows back-to-back with one IDLE cycle between; each count_out correct.
- REQ-034: WINDOW=1; start, then pulse_in=1 on the next edge -> count_valid=1 and count_out=1 one cycle after start.
- REQ-035: rst_n pulsed low at window edge 8 -> all outputs 0 at once, no count_valid afterwards; a fresh start gives a correct full window.
